intr_ctrl: RTL and testbench

Parametrised interrupt controller that takes N_SRC interrupt request lines and presents one IRQ with the winning source ID to a CPU-side or bus-side driver. Each source can be level- or edge-sensitive and can be masked individually. Arbitration is fixed-priority or round-robin. An ack handshake clears edge-latched requests. It sits between the peripheral request lines (the IREQ bundle) and the interrupt agent or bus slave that services them.

---
 rtl/intr_ctrl.sv | 93 +++++++++
 tb/tb_intr_ctrl.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/intr_ctrl.sv
// Interrupt controller: per-source level/edge capture and masking, fixed-priority
// or round-robin arbitration, and a registered IRQ/irq_id with an ack handshake.
module intr_ctrl #(
    parameter int N_SRC = 8,
    parameter int ID_W  = $clog2(N_SRC),
    parameter bit RR    = 1'b0
) (
    input  logic             PCLK,
    input  logic             PRESETn,
    input  logic [N_SRC-1:0] IREQ,
    input  logic [N_SRC-1:0] mode,
    input  logic [N_SRC-1:0] mask_en,
    input  logic             ack,
    output logic             IRQ,
    output logic [ID_W-1:0]  irq_id,
    output logic [N_SRC-1:0] pending
);

    typedef enum logic {IDLE, PRESENT} state_t;

    state_t           state;
    logic [N_SRC-1:0] ireq_q, ireq_q2, rise, eligible;
    logic [ID_W-1:0]  rr_ptr, winner, id_next, idx;
    logic [ID_W:0]    sum;
    logic             found, ack_acc;

    assign rise     = ireq_q & ~ireq_q2;
    assign eligible = pending & mask_en;
    // An ack in the same cycle the presented source drops out is ignored.
    assign ack_acc  = (state == PRESENT) && ack && eligible[irq_id];
    assign id_next  = (irq_id == ID_W'(N_SRC - 1)) ? '0 : irq_id + 1'b1;

    // Cyclic search from rr_ptr; with RR off the start point is always 0.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        sum    = '0;
        idx    = '0;
        for (int k = 0; k < N_SRC; k++) begin
            sum = (RR ? {1'b0, rr_ptr} : '0) + (ID_W+1)'(k);
            if (sum >= (ID_W+1)'(N_SRC))
                sum = sum - (ID_W+1)'(N_SRC);
            idx = sum[ID_W-1:0];
            if (!found && eligible[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            ireq_q  <= '0;
            ireq_q2 <= '0;
            pending <= '0;
            rr_ptr  <= '0;
            irq_id  <= '0;
            IRQ     <= 1'b0;
            state   <= IDLE;
        end else begin
            ireq_q  <= IREQ;
            ireq_q2 <= ireq_q;
            // Edge sources: a new rise beats a clearing ack.
            for (int i = 0; i < N_SRC; i++) begin
                if (mode[i])
                    pending[i] <= rise[i] | (pending[i] & ~(ack_acc && irq_id == ID_W'(i)));
                else
                    pending[i] <= ireq_q[i];
            end
            case (state)
                IDLE: begin
                    if (|eligible) begin
                        irq_id <= winner;
                        IRQ    <= 1'b1;
                        state  <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (!eligible[irq_id]) begin
                        IRQ   <= 1'b0;
                        state <= IDLE;
                    end else if (ack) begin
                        IRQ    <= 1'b0;
                        rr_ptr <= id_next;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_intr_ctrl.sv
// Bench for intr_ctrl: a fixed-priority and a round-robin instance, each with
// an expected-ID queue popped whenever its IRQ rises.
module tb_intr_ctrl;

    logic       PCLK = 1'b0;
    logic       rstn0, rstn1, ack0, ack1;
    logic [7:0] ireq0, mode0, mask0, ireq1, mode1, mask1;
    logic       irq0, irq1;
    logic [2:0] id0, id1;
    logic [7:0] pend0, pend1;

    int n_chk = 0;
    int n_fail = 0;
    int q0[$];
    int q1[$];
    logic irq0_d = 1'b0;
    logic irq1_d = 1'b0;

    always #5 PCLK = ~PCLK;

    intr_ctrl #(.N_SRC(8), .RR(1'b0)) dut0 (
        .PCLK(PCLK), .PRESETn(rstn0), .IREQ(ireq0), .mode(mode0), .mask_en(mask0),
        .ack(ack0), .IRQ(irq0), .irq_id(id0), .pending(pend0)
    );

    intr_ctrl #(.N_SRC(8), .RR(1'b1)) dut1 (
        .PCLK(PCLK), .PRESETn(rstn1), .IREQ(ireq1), .mode(mode1), .mask_en(mask1),
        .ack(ack1), .IRQ(irq1), .irq_id(id1), .pending(pend1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    // Scoreboards: every new presentation must match the next expected source.
    always @(negedge PCLK) begin
        if (irq0 && !irq0_d) begin
            if (q0.size() == 0) chk("sb0_unexpected_irq", 32'(q0.size()), 1);
            else chk("sb0_id", 32'(id0), q0.pop_front());
        end
        irq0_d <= irq0;
    end

    always @(negedge PCLK) begin
        if (irq1 && !irq1_d) begin
            if (q1.size() == 0) chk("sb1_unexpected_irq", 32'(q1.size()), 1);
            else chk("sb1_id", 32'(id1), q1.pop_front());
        end
        irq1_d <= irq1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn0 = 0; rstn1 = 0; ack0 = 0; ack1 = 0;
        ireq0 = 0; mode0 = 0; mask0 = 0; ireq1 = 0; mode1 = 0; mask1 = 0;
        tick(); tick();
        chk("rst_irq0", 32'(irq0), 0);
        chk("rst_id0", 32'(id0), 0);
        chk("rst_pend0", 32'(pend0), 0);
        chk("rst_irq1", 32'(irq1), 0);
        rstn0 = 1; rstn1 = 1;

        // Level source 3, fixed priority.
        mask0 = 8'h08; ireq0 = 8'h08; q0.push_back(3);
        tick(); chk("lvl_k_irq", 32'(irq0), 0);
        tick(); chk("lvl_k1_pend", 32'(pend0), 8'h08); chk("lvl_k1_irq", 32'(irq0), 0);
        tick(); chk("lvl_k2_irq", 32'(irq0), 1); chk("lvl_k2_id", 32'(id0), 3);
        ack0 = 1; q0.push_back(3);
        tick(); ack0 = 0; chk("lvl_ack_irq", 32'(irq0), 0);
        tick(); chk("lvl_re_irq", 32'(irq0), 1); chk("lvl_re_id", 32'(id0), 3);
        ireq0 = 0;
        tick(); chk("lvl_drop1_irq", 32'(irq0), 1);
        tick(); chk("lvl_drop2_irq", 32'(irq0), 1); chk("lvl_drop2_pend", 32'(pend0), 0);
        tick(); chk("lvl_wd_irq", 32'(irq0), 0);
        tick();

        // Edge sources 1 and 5 pulsed together.
        mode0 = 8'h22; mask0 = 8'hFF; ireq0 = 8'h22; q0.push_back(1);
        tick(); ireq0 = 0;
        tick(); chk("edge_pend", 32'(pend0), 8'h22);
        tick(); chk("edge_irq", 32'(irq0), 1); chk("edge_id", 32'(id0), 1);
        ack0 = 1; q0.push_back(5);
        tick(); ack0 = 0; chk("edge_ack1_irq", 32'(irq0), 0); chk("edge_ack1_pend", 32'(pend0), 8'h20);
        tick(); chk("edge_id5", 32'(id0), 5); chk("edge_irq5", 32'(irq0), 1);
        ack0 = 1;
        tick(); ack0 = 0; chk("edge_ack2_pend", 32'(pend0), 0); chk("edge_ack2_irq", 32'(irq0), 0);
        tick(); chk("edge_quiet_irq", 32'(irq0), 0);

        // Rise on source 2 coincides with its ack.
        mode0 = 8'h04; ireq0 = 8'h04; q0.push_back(2);
        tick(); ireq0 = 0;
        tick();
        tick(); chk("coin_id", 32'(id0), 2);
        ireq0 = 8'h04;
        tick(); ireq0 = 0; ack0 = 1; q0.push_back(2);
        tick(); ack0 = 0; chk("coin_irq", 32'(irq0), 0); chk("coin_pend", 32'(pend0), 8'h04);
        tick(); chk("coin_re_irq", 32'(irq0), 1); chk("coin_re_id", 32'(id0), 2);
        ack0 = 1;
        tick(); ack0 = 0; chk("coin_clr_pend", 32'(pend0), 0);

        // Masking of edge source 4.
        mode0 = 8'h10; mask0 = 8'hEF; ireq0 = 8'h10;
        tick(); ireq0 = 0;
        tick(); chk("mask_pend", 32'(pend0), 8'h10); chk("mask_irq", 32'(irq0), 0);
        tick(); chk("mask_irq2", 32'(irq0), 0);
        mask0 = 8'hFF; q0.push_back(4);
        tick(); chk("unmask_irq", 32'(irq0), 1); chk("unmask_id", 32'(id0), 4);
        mask0 = 8'hEF;
        tick(); chk("remask_irq", 32'(irq0), 0); chk("remask_pend", 32'(pend0), 8'h10);
        mask0 = 8'hFF; q0.push_back(4);
        tick(); chk("mask_back_irq", 32'(irq0), 1);
        ack0 = 1;
        tick(); ack0 = 0; chk("mask_ack_pend", 32'(pend0), 0);

        // Round-robin over 8 level sources, including wrap 7 -> 0.
        mask1 = 8'hFF; ireq1 = 8'hFF; q1.push_back(0);
        tick(); tick(); tick();
        for (int n = 0; n < 9; n++) begin
            chk("rr_irq", 32'(irq1), 1);
            chk("rr_id", 32'(id1), 32'((n + 1) % 8 == 0 ? 7 : n % 8));
            q1.push_back((n + 1) % 8);
            if (n == 8) ireq1 = 0;
            ack1 = 1;
            tick(); ack1 = 0; chk("rr_gap", 32'(irq1), 0);
            tick();
        end
        chk("rr_last_id", 32'(id1), 1);
        tick(); chk("rr_wd_irq", 32'(irq1), 0);

        // Reset mid-presentation with ack held; edge source 6 stays high.
        mode1 = 8'h44; ireq1 = 8'h04; q1.push_back(2);
        tick(); ireq1 = 0;
        tick();
        tick(); chk("rst_pre_id2", 32'(id1), 2);
        ireq1 = 8'h40; ack1 = 1; q1.push_back(6);
        tick(); ack1 = 0; chk("rst_pre_gap", 32'(irq1), 0);
        tick();
        tick(); chk("rst_pre_irq", 32'(irq1), 1); chk("rst_pre_id6", 32'(id1), 6);
        rstn1 = 0; ack1 = 1;
        tick(); rstn1 = 1; ack1 = 0;
        chk("mid_rst_irq", 32'(irq1), 0); chk("mid_rst_id", 32'(id1), 0); chk("mid_rst_pend", 32'(pend1), 0);
        q1.push_back(6);
        tick(); chk("post_rst_irq_a", 32'(irq1), 0);
        tick(); chk("post_rst_pend", 32'(pend1), 8'h40); chk("post_rst_irq_b", 32'(irq1), 0);
        tick(); chk("post_rst_irq", 32'(irq1), 1); chk("post_rst_id", 32'(id1), 6);
        tick();

        chk("sb0_left", 32'(q0.size()), 0);
        chk("sb1_left", 32'(q1.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
